// File: rtl/uart_pkg.sv
// Shared types, constants and the parity helper for the UART transmitter.
package uart_pkg;

  localparam int unsigned DEFAULT_CLK_DIV = 434;
  localparam int unsigned MAX_DATA_BITS   = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

  // Even parity is the XOR of the data; odd parity is its complement.
  function automatic logic parity_bit(input logic [MAX_DATA_BITS-1:0] data, input logic odd);
    return odd ? ~^data : ^data;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous first-word fall-through FIFO with a separate occupancy counter.
module uart_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             do_push, do_pop;

  assign full  = (level_q == LVL_W'(DEPTH));
  assign empty = (level_q == '0);
  assign level = level_q;
  assign rdata = mem_q[rd_ptr_q];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    do_push  = push && !full;
    do_pop   = pop && !empty;
    if (do_push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by an input FIFO with a valid/ready write port.
// Build option: define UART_TX_PARITY_EN to insert a parity bit after the data bits.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned CLK_DIV    = DEFAULT_CLK_DIV,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_BITS-1:0]          wdata,
  input  logic                          wvalid,
  output logic                          wready,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int unsigned CNT_W = $clog2(CLK_DIV);
  localparam int unsigned BIT_W = $clog2(MAX_DATA_BITS);
  localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;

  if (CLK_DIV < 2) begin : g_bad_clk_div
    $error("uart_tx_fifo: CLK_DIV must be at least 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > MAX_DATA_BITS) begin : g_bad_data_bits
    $error("uart_tx_fifo: DATA_BITS must be in 5..8");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_tx_fifo: FIFO_DEPTH must be a power of two, at least 2");
  end
  if (PARITY_ODD > 1) begin : g_bad_parity_odd
    $error("uart_tx_fifo: PARITY_ODD must be 0 or 1");
  end

  tx_state_e            state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 tx_q, tx_d;
`ifdef UART_TX_PARITY_EN
  logic                 par_q, par_d;
`endif
  logic                 bit_tick;
  logic                 fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [DATA_BITS-1:0] fifo_rdata;
  logic [LVL_W-1:0]     fifo_cnt;

  // A full FIFO refuses writes regardless of a same-cycle pop.
  assign wready    = !fifo_full && !rst;
  assign fifo_push = wvalid && wready;

  uart_sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .wdata (wdata),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_cnt)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = '0;
    bit_d    = bit_q;
    shift_d  = shift_q;
    fifo_pop = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d    = par_q;
`endif
    // Baud counter idles at zero so every bit is exactly CLK_DIV cycles.
    bit_tick = (state_q != IDLE) && (cnt_q == CNT_W'(CLK_DIV - 1));
    if (state_q != IDLE && !bit_tick) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          state_d  = START;
        end
      end
      START: begin
        if (bit_tick) begin
          state_d = DATA;
          bit_d   = '0;
        end
      end
      DATA: begin
        if (bit_tick) begin
          shift_d = shift_q >> 1;
          if (bit_q == BIT_W'(DATA_BITS - 1)) begin
            bit_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_tick) begin
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        if (bit_tick) begin
          if (bit_q == BIT_W'(STOP_BITS - 1)) begin
            bit_d = '0;
            if (!fifo_empty) begin
              fifo_pop = 1'b1;
              state_d  = START;
            end else begin
              state_d = IDLE;
            end
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Every pop loads the next frame's payload.
    if (fifo_pop) begin
      shift_d = fifo_rdata;
`ifdef UART_TX_PARITY_EN
      par_d   = parity_bit(MAX_DATA_BITS'(fifo_rdata), PARITY_ODD != 0);
`endif
    end

    // Line level follows the registered state one cycle later.
    case (state_q)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_q[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_d = par_q;
`endif
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign tx         = tx_q;
  assign busy       = (state_q != IDLE) || (fifo_cnt != '0);
  assign fifo_level = fifo_cnt;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomized self-checking bench for uart_tx_fifo against a frame-level line model.
module tb_uart_tx_fifo;

  localparam int DIV    = 4;
  localparam int DB     = 8;
  localparam int DEPTH  = 16;
  localparam int DEPTH2 = 4;
`ifdef UART_TX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int F1 = (1 + DB + PB + 1) * DIV;
  localparam int F2 = (1 + DB + PB + 2) * DIV;

  logic       clk    = 1'b0;
  logic       rst    = 1'b1;
  logic [7:0] wdata  = '0;
  logic [7:0] wdata2 = '0;
  logic       wvalid  = 1'b0;
  logic       wvalid2 = 1'b0;
  logic       wready, tx, busy;
  logic       wready2, tx2, busy2;
  logic [4:0] fifo_level;
  logic [2:0] fifo_level2;

  int         errors = 0;
  int         checks = 0;
  int         cyc    = 0;
  int         frames = 0;
  bit         mon_on = 1'b0;
  logic [7:0] exp_q[$];
  int         start_q[$];

  uart_tx_fifo #(
    .CLK_DIV(DIV), .DATA_BITS(DB), .STOP_BITS(1), .FIFO_DEPTH(DEPTH), .PARITY_ODD(0)
  ) u_dut (
    .clk(clk), .rst(rst), .wdata(wdata), .wvalid(wvalid), .wready(wready),
    .tx(tx), .busy(busy), .fifo_level(fifo_level)
  );

  uart_tx_fifo #(
    .CLK_DIV(DIV), .DATA_BITS(DB), .STOP_BITS(2), .FIFO_DEPTH(DEPTH2), .PARITY_ODD(1)
  ) u_dut2 (
    .clk(clk), .rst(rst), .wdata(wdata2), .wvalid(wvalid2), .wready(wready2),
    .tx(tx2), .busy(busy2), .fifo_level(fifo_level2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Line level of bit slot k of a frame: start, data LSB first, parity, then stop ones.
  function automatic logic frame_bit(input logic [7:0] d, input int k, input logic odd);
    if (k == 0) return 1'b0;
    if (k <= DB) return d[k-1];
    if (PB == 1 && k == DB + 1) return odd ? ~^d : ^d;
    return 1'b1;
  endfunction

  // Offer one word; acc is the edge number at which it was accepted.
  task automatic push_word(input bit sel, input logic [7:0] d, output int acc);
    acc = -1;
    if (sel) begin wdata2 = d; wvalid2 = 1'b1; end
    else begin wdata = d; wvalid = 1'b1; end
    for (int i = 0; i < 4000; i++) begin
      if ((sel ? wready2 : wready) == 1'b1) begin
        acc = cyc + 1;
        if (!sel) exp_q.push_back(d);
        step();
        break;
      end
      step();
    end
    wvalid  = 1'b0;
    wvalid2 = 1'b0;
    check_eq("push_accepted", 32'(acc >= 0), 32'd1);
  endtask

  task automatic wait_idle(input int budget, output int fall);
    fall = -1;
    for (int i = 0; i < budget; i++) begin
      step();
      if (!busy) begin
        fall = cyc;
        break;
      end
    end
    check_eq("idle_reached", 32'(fall >= 0), 32'd1);
  endtask

  // Frame decoder: every cycle of a frame is compared with the expected line level.
  initial begin : monitor
    logic [7:0] d;
    bit         done;
    forever begin
      step();
      if (mon_on && tx === 1'b0) begin
        start_q.push_back(cyc);
        check_eq("frame_expected", 32'(exp_q.size() != 0), 32'd1);
        d = (exp_q.size() != 0) ? exp_q.pop_front() : 8'h00;
        done = 1'b1;
        for (int i = 0; i < F1; i++) begin
          if (i != 0) step();
          if (!mon_on) begin
            done = 1'b0;
            break;
          end
          check_eq("tx_bit", 32'(tx), 32'(frame_bit(d, i / DIV, 1'b0)));
        end
        if (done) frames++;
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin : main
    int         acc, fall, s, k, n0, lows, rel;
    logic [7:0] words [20];
    logic [7:0] d2;

    step();
    step();
    check_eq("rst_wready", 32'(wready), 32'd0);
    check_eq("rst_wready2", 32'(wready2), 32'd0);
    check_eq("rst_tx", 32'(tx), 32'd1);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_level", 32'(fifo_level), 32'd0);
    rst = 1'b0;
    step();
    check_eq("wready_after_rst", 32'(wready), 32'd1);
    check_eq("wready2_after_rst", 32'(wready2), 32'd1);
    mon_on = 1'b1;

    // Single frame: latency to start bit and busy duration.
    push_word(1'b0, 8'h55, acc);
    wait_idle(400, fall);
    check_eq("busy_fall", 32'(fall), 32'(acc + 1 + F1));
    repeat (3) step();
    check_eq("t1_frames", 32'(frames), 32'd1);
    check_eq("t1_latency", 32'(start_q[0]), 32'(acc + 2));

    // A few isolated frames, including the parity example word.
    for (int j = 0; j < 3; j++) begin
      push_word(1'b0, (j == 0) ? 8'h07 : 8'($urandom), acc);
      wait_idle(400, fall);
      check_eq("single_busy_fall", 32'(fall), 32'(acc + 1 + F1));
    end

    // Back-to-back words: no idle gap between frames.
    repeat (3) step();
    n0 = start_q.size();
    push_word(1'b0, 8'hA3, acc);
    push_word(1'b0, 8'h3C, acc);
    wait_idle(800, fall);
    repeat (3) step();
    check_eq("t4_frames", 32'(start_q.size() - n0), 32'd2);
    check_eq("t4_gap", 32'(start_q[n0+1] - start_q[n0]), 32'(F1));

    // Flood the FIFO while a frame is in flight.
    push_word(1'b0, 8'($urandom), acc);
    repeat (4) step();
    s  = start_q[start_q.size()-1];
    n0 = frames;
    foreach (words[i]) words[i] = 8'($urandom);
    k = 0;
    for (int t = 0; t < 400 && k < 20; t++) begin
      wdata  = words[k];
      wvalid = 1'b1;
      if (cyc <= s + F1 - 2) begin
        check_eq("t3_level", 32'(fifo_level), 32'(k));
        check_eq("t3_wready", 32'(wready), 32'(k < DEPTH));
      end
      if (wready) begin
        exp_q.push_back(words[k]);
        k++;
      end
      step();
    end
    wvalid = 1'b0;
    check_eq("t3_all_accepted", 32'(k), 32'd20);
    wait_idle(3000, fall);
    repeat (3) step();
    check_eq("t3_frames", 32'(frames - n0), 32'd21);
    check_eq("t3_queue_drained", 32'(exp_q.size()), 32'd0);

    // Two stop bits (odd parity when enabled), checked cycle by cycle.
    for (int j = 0; j < 3; j++) begin
      d2 = (j == 0) ? 8'hFF : 8'($urandom);
      push_word(1'b1, d2, acc);
      for (int t = 0; t < F2 + 6; t++) begin
        step();
        rel = cyc - (acc + 2);
        check_eq("t5_tx", 32'(tx2),
                 32'((rel >= 0 && rel < F2) ? frame_bit(d2, rel / DIV, 1'b1) : 1'b1));
        check_eq("t5_busy", 32'(busy2), 32'(cyc < acc + 1 + F2));
      end
    end

    // Reset in the middle of a frame with three words queued.
    n0 = frames;
    for (int j = 0; j < 4; j++) push_word(1'b0, 8'($urandom), acc);
    repeat (10) step();
    check_eq("t6_level_before", 32'(fifo_level), 32'd3);
    mon_on = 1'b0;
    rst    = 1'b1;
    step();
    check_eq("t6_tx", 32'(tx), 32'd1);
    check_eq("t6_level", 32'(fifo_level), 32'd0);
    check_eq("t6_busy", 32'(busy), 32'd0);
    check_eq("t6_wready", 32'(wready), 32'd0);
    rst = 1'b0;
    exp_q.delete();
    step();
    mon_on = 1'b1;
    lows = 0;
    repeat (200) begin
      step();
      if (tx !== 1'b1) lows++;
    end
    check_eq("t6_line_silent", 32'(lows), 32'd0);
    check_eq("t6_no_frames", 32'(frames), 32'(n0));
    check_eq("t6_idle", 32'(busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
